fft_frame_loader: RTL

- Streaming front end for the FFT processing unit.
- Accepts ADC samples serially over a valid/ready handshake and assembles N_POINTS-sample frames in a ping-pong register buffer, optionally in bit-reversed order.
- Converts each sample to signed fixed point (DATA_WIDTH, FRACTION fractional bits) and presents a complete real-valued frame on a flat parallel bus with its own valid/ready handshake.
- Successor to the fixed 32-input, 8-bit parallel load: point count, widths, signedness and ordering are generalised, and framing errors and backpressure are handled.

---
 rtl/fft_frame_loader_if.sv | 27 ++
 rtl/fft_frame_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/fft_frame_loader_if.sv
// Handshake bundle between the ADC sample source, the frame loader and the FFT PU.
// master drives samples and accepts frames; slave is the loader itself.
interface fft_frame_loader_if #(
    parameter int N_POINTS       = 32,
    parameter int ADC_DATA_WIDTH = 8,
    parameter int DATA_WIDTH     = 32
);
    logic                           s_valid;
    logic                           s_ready;
    logic [ADC_DATA_WIDTH-1:0]      s_data;
    logic                           s_last;
    logic                           frame_valid;
    logic                           frame_ready;
    logic [N_POINTS*DATA_WIDTH-1:0] frame_data;
    logic                           frame_err;
    logic [7:0]                     err_count;

    modport master (
        output s_valid, s_data, s_last, frame_ready,
        input  s_ready, frame_valid, frame_data, frame_err, err_count
    );

    modport slave (
        input  s_valid, s_data, s_last, frame_ready,
        output s_ready, frame_valid, frame_data, frame_err, err_count
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Streaming front end for the FFT PU: serial ADC samples are assembled into
// N_POINTS-sample frames in two ping-pong banks (optionally bit-reversed),
// converted to fixed point and presented as one flat parallel word bus.
// The two banks behave as a depth-2 frame FIFO; a malformed frame is dropped.
module fft_frame_loader #(
    parameter int N_POINTS       = 32,
    parameter int ADC_DATA_WIDTH = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int FRACTION       = 16,
    parameter bit SIGNED_IN      = 1'b0,
    parameter bit BIT_REVERSE    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    fft_frame_loader_if.slave bus
);
    localparam int AW = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

    logic [ADC_DATA_WIDTH-1:0] mem [2][N_POINTS];
    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_cnt;
    logic          frame_err;
    logic [7:0]    err_count;

    logic          accept;
    logic          consume;
    logic          at_last;
    logic          frame_done;
    logic          framing_err;
    logic [AW-1:0] wr_idx;
    logic [N_POINTS*DATA_WIDTH-1:0] frame_flat;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = v[AW-1-b];
        end
        return r;
    endfunction

    assign bus.s_ready     = reset & ~full[wr_bank];
    assign bus.frame_valid = full[rd_bank];
    assign bus.frame_err   = frame_err;
    assign bus.err_count   = err_count;
    assign bus.frame_data  = frame_flat;

    assign accept      = bus.s_valid & bus.s_ready;
    assign consume     = bus.frame_valid & bus.frame_ready;
    assign at_last     = (wr_cnt == LAST_IDX);
    assign frame_done  = accept & at_last & bus.s_last;
    // s_last early, or the final slot filled without s_last, both break framing
    assign framing_err = accept & (at_last ^ bus.s_last);
    assign wr_idx      = BIT_REVERSE ? bitrev(wr_cnt) : wr_cnt;

    // Sample storage: written on accept, deliberately not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][wr_idx] <= bus.s_data;
        end
    end

    // Bank flags, pointers and error bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            frame_err <= 1'b0;
            err_count <= 8'd0;
        end else begin
            // frame_done needs wr_bank empty and consume needs rd_bank full,
            // so the two never target the same bank in one edge
            for (int b = 0; b < 2; b++) begin
                if (frame_done && (wr_bank == b[0])) begin
                    full[b] <= 1'b1;
                end else if (consume && (rd_bank == b[0])) begin
                    full[b] <= 1'b0;
                end
            end
            if (frame_done) begin
                wr_bank <= ~wr_bank;
            end
            if (consume) begin
                rd_bank <= ~rd_bank;
            end
            if (accept) begin
                wr_cnt <= (frame_done || framing_err) ? '0 : wr_cnt + 1'b1;
            end
            frame_err <= framing_err;
            if (framing_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < N_POINTS; i++) begin : g_word
        logic [ADC_DATA_WIDTH-1:0] raw;
        logic [DATA_WIDTH-1:0]     ext;

        // Sign- or zero-extend the stored code; fixed point comes from the shift
        always_comb begin
            raw = mem[rd_bank][i];
            ext = {DATA_WIDTH{SIGNED_IN && raw[ADC_DATA_WIDTH-1]}};
            ext[ADC_DATA_WIDTH-1:0] = raw;
        end

        assign frame_flat[i*DATA_WIDTH +: DATA_WIDTH] = ext << FRACTION;
    end
endmodule
